instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/cpu8_pkg.sv | 29 ++
 rtl/instr_fetch_pc.sv | 29 ++
 rtl/instr_fetch.sv | 96 +++++++++
 tb/tb_instr_fetch.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu8_pkg.sv
// rtl/cpu8_pkg.sv - shared cpu8 fetch-state encoding, defaults and instruction field positions
package cpu8_pkg;

    localparam int         DEFAULT_ADDR_W   = 8;
    localparam logic [7:0] DEFAULT_RESET_PC = 8'h00;
    localparam int         INSTR_W          = 8;

    // Opcode and register fields overlap on bit 5; the control unit decodes per opcode.
    localparam int OPCODE_MSB = 7;
    localparam int OPCODE_LSB = 5;
    localparam int REG_MSB    = 5;
    localparam int REG_LSB    = 0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_HALT  = 2'd3
    } fetch_state_t;

    function automatic logic [OPCODE_MSB-OPCODE_LSB:0] instr_opcode(input logic [INSTR_W-1:0] i_instr);
        return i_instr[OPCODE_MSB:OPCODE_LSB];
    endfunction

    function automatic logic [REG_MSB-REG_LSB:0] instr_reg(input logic [INSTR_W-1:0] i_instr);
        return i_instr[REG_MSB:REG_LSB];
    endfunction

endpackage

// File: rtl/instr_fetch_pc.sv
// rtl/instr_fetch_pc.sv - program counter with jump load, increment and natural wrap
module instr_fetch_pc #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_load_addr,
    input  logic              i_inc,
    output logic [ADDR_W-1:0] o_pc
);

    logic [ADDR_W-1:0] r_pc;

    // A jump outranks the increment; the add wraps modulo 2^ADDR_W by width.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (i_load) begin
            r_pc <= i_load_addr;
        end else if (i_inc) begin
            r_pc <= r_pc + 1'b1;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - single-outstanding instruction fetch FSM with instruction register
module instr_fetch
    import cpu8_pkg::*;
#(
    parameter int                ADDR_W   = DEFAULT_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_req,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               mem_ack,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               jump_en,
    input  logic [ADDR_W-1:0]  jump_addr,
    input  logic               halt,
    output logic [ADDR_W-1:0]  pc
);

    fetch_state_t       r_state;
    logic [INSTR_W-1:0] r_instr;
    logic               r_instr_valid;
    logic [ADDR_W-1:0]  w_pc;
    logic               w_fetch_live;
    logic               w_pc_inc;

    // A request is live only in FETCH without halt; a jump in that cycle discards any ack.
    assign w_fetch_live = (r_state == S_FETCH) && !halt;
    assign w_pc_inc     = w_fetch_live && !jump_en && mem_ack;

    instr_fetch_pc #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (jump_en),
        .i_load_addr (jump_addr),
        .i_inc       (w_pc_inc),
        .o_pc        (w_pc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_FETCH;
                end
                S_FETCH: begin
                    if (halt) begin
                        r_state <= S_HALT;
                    end else if (jump_en) begin
                        r_state <= S_FETCH;
                    end else if (mem_ack) begin
                        r_instr       <= mem_rdata;
                        r_instr_valid <= 1'b1;
                        r_state       <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    // A flush still counts a same-cycle handshake as accepted.
                    if (jump_en) begin
                        r_instr_valid <= 1'b0;
                        r_state       <= S_FETCH;
                    end else if (instr_ready) begin
                        r_instr_valid <= 1'b0;
                        r_state       <= halt ? S_HALT : S_FETCH;
                    end
                end
                S_HALT: begin
                    if (!halt) begin
                        r_state <= S_FETCH;
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_instr_valid <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req     = w_fetch_live;
    assign mem_addr    = w_pc;
    assign pc          = w_pc;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch against an event-level fetch model
module tb_instr_fetch;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] mem_addr;
    logic       mem_req;
    logic [7:0] mem_rdata;
    logic       mem_ack;
    logic [7:0] instr;
    logic       instr_valid;
    logic       instr_ready;
    logic       jump_en;
    logic [7:0] jump_addr;
    logic       halt;
    logic [7:0] pc;

    always #5 clk = ~clk;

    instr_fetch #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_addr    (mem_addr),
        .mem_req     (mem_req),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .jump_en     (jump_en),
        .jump_addr   (jump_addr),
        .halt        (halt),
        .pc          (pc)
    );

    logic [7:0] mem [256];
    int n_checks = 0;
    int n_fail   = 0;

    // Model: warming up after reset, presenting an instruction, parked by halt, else waiting on memory.
    bit         m_boot;
    bit         m_present;
    bit         m_halted;
    logic [7:0] m_pc;
    logic [7:0] m_instr;

    function automatic bit m_fetching();
        return !m_boot && !m_present && !m_halted;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_boot    = 1'b1;
        m_present = 1'b0;
        m_halted  = 1'b0;
        m_pc      = 8'h00;
        m_instr   = 8'h00;
    endtask

    task automatic model_edge(input bit rst, input bit ack, input bit rdy,
                              input bit jmp, input logic [7:0] ja, input bit hlt);
        if (!rst) begin
            model_reset();
        end else if (m_boot) begin
            m_boot = 1'b0;
            if (jmp) m_pc = ja;
        end else if (m_halted) begin
            if (jmp) m_pc = ja;
            if (!hlt) m_halted = 1'b0;
        end else if (m_present) begin
            if (jmp) begin
                m_pc      = ja;
                m_present = 1'b0;
            end else if (rdy) begin
                m_present = 1'b0;
                m_halted  = hlt;
            end
        end else begin
            if (jmp) m_pc = ja;
            if (hlt) begin
                m_halted = 1'b1;
            end else if (!jmp && ack) begin
                m_instr   = mem[m_pc];
                m_pc      = m_pc + 8'd1;
                m_present = 1'b1;
            end
        end
    endtask

    task automatic step(input bit rst, input bit ack, input bit rdy,
                        input bit jmp, input logic [7:0] ja, input bit hlt);
        @(negedge clk);
        rst_n       = rst;
        mem_ack     = ack;
        instr_ready = rdy;
        jump_en     = jmp;
        jump_addr   = ja;
        halt        = hlt;
        mem_rdata   = mem[mem_addr];
        #1;
        chk("mem_req", mem_req, m_fetching() && !hlt);
        chk("mem_addr", mem_addr, m_pc);
        chk("pc", pc, m_pc);
        chk("instr_valid", instr_valid, m_present);
        if (m_present) chk("instr", instr, m_instr);
        model_edge(rst, ack, rdy, jmp, ja, hlt);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    int n_xfer;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[8'h00] = 8'h3A;
        mem[8'h01] = 8'h5B;
        mem[8'hFF] = 8'hE7;
        mem[8'h10] = 8'h99;
        mem[8'h40] = 8'hC5;

        rst_n = 1'b0; mem_ack = 1'b0; mem_rdata = 8'h00; instr_ready = 1'b0;
        jump_en = 1'b0; jump_addr = 8'h00; halt = 1'b0;
        settle();
        model_reset();
        chk("reset_valid", instr_valid, 1'b0);
        chk("reset_instr", instr, 8'h00);
        chk("reset_pc", pc, 8'h00);
        chk("reset_req", mem_req, 1'b0);

        // Same-cycle ack at addr 0.
        step(1, 0, 0, 0, 8'h00, 0);
        step(1, 1, 1, 0, 8'h00, 0);
        settle();
        chk("first_instr", instr, 8'h3A);
        chk("first_valid", instr_valid, 1'b1);
        chk("first_pc", pc, 8'h01);
        chk("model_first_instr", m_instr, 8'h3A);
        step(1, 0, 1, 0, 8'h00, 0);

        // Stall with ready low for five cycles.
        step(1, 1, 0, 0, 8'h00, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 0, 8'h00, 0);
            chk("stall_req", mem_req, 1'b0);
            chk("stall_instr", instr, 8'h5B);
            chk("stall_valid", instr_valid, 1'b1);
        end
        step(1, 0, 1, 0, 8'h00, 0);
        settle();
        chk("stall_done_valid", instr_valid, 1'b0);

        // Wrap from FF.
        step(1, 0, 0, 1, 8'hFF, 0);
        step(1, 1, 0, 0, 8'h00, 0);
        settle();
        chk("wrap_pc", pc, 8'h00);
        chk("wrap_instr", instr, 8'hE7);
        chk("model_wrap_pc", m_pc, 8'h00);
        step(1, 0, 1, 0, 8'h00, 0);

        // Jump in the ack cycle of addr 10.
        step(1, 0, 0, 1, 8'h10, 0);
        step(1, 1, 0, 1, 8'h40, 0);
        settle();
        chk("jump_addr", mem_addr, 8'h40);
        chk("jump_no_valid", instr_valid, 1'b0);
        step(1, 0, 0, 0, 8'h00, 0);
        chk("jump_still_no_valid", instr_valid, 1'b0);

        // Halt four cycles from FETCH at 40.
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 0, 8'h00, 1);
            chk("halt_req", mem_req, 1'b0);
        end
        step(1, 0, 0, 0, 8'h00, 0);
        settle();
        chk("halt_resume_pc", pc, 8'h40);
        chk("halt_resume_req", mem_req, 1'b1);

        // Reset while holding C5.
        step(1, 1, 0, 0, 8'h00, 0);
        settle();
        chk("hold_c5", instr, 8'hC5);
        step(0, 1, 0, 0, 8'h00, 0);
        settle();
        chk("rst_hold_valid", instr_valid, 1'b0);
        chk("rst_hold_instr", instr, 8'h00);
        chk("rst_hold_pc", pc, 8'h00);

        // Back-to-back single-cycle memory: one instruction per two cycles.
        step(1, 0, 0, 0, 8'h00, 0);
        n_xfer = 0;
        for (int i = 0; i < 10; i++) begin
            step(1, 1, 1, 0, 8'h00, 0);
            if (instr_valid && instr_ready) n_xfer++;
        end
        chk("throughput", n_xfer, 5);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            bit r_rst, r_hlt, r_jmp, r_rdy, r_ack;
            r_rst = ($urandom_range(99) != 0);
            r_hlt = ($urandom_range(7) == 0);
            r_jmp = ($urandom_range(7) == 0);
            r_rdy = $urandom_range(1);
            r_ack = (m_fetching() && !r_hlt) ? ($urandom_range(2) != 0) : 1'b0;
            step(r_rst, r_ack, r_rdy, r_jmp, 8'($urandom), r_hlt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
